// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the MEM pipeline stage and the data memory.
interface data_memory_responder_if;
    logic        ReqIn;
    logic        MemReadIn;
    logic        MemWriteIn;
    logic        LoadStoreByteIn;
    logic        LoadStoreHalfIn;
    logic [31:0] AddressIn;
    logic [31:0] WriteDataIn;
    logic        ReadyOut;
    logic        DoneOut;
    logic [31:0] ReadDataOut;
    logic        MisalignOut;
    logic        StallOut;

    // Pipeline side: issues requests, consumes responses.
    modport master (
        output ReqIn, MemReadIn, MemWriteIn, LoadStoreByteIn, LoadStoreHalfIn,
               AddressIn, WriteDataIn,
        input  ReadyOut, DoneOut, ReadDataOut, MisalignOut, StallOut
    );

    // Memory side: consumes requests, produces responses.
    modport slave (
        input  ReqIn, MemReadIn, MemWriteIn, LoadStoreByteIn, LoadStoreHalfIn,
               AddressIn, WriteDataIn,
        output ReadyOut, DoneOut, ReadDataOut, MisalignOut, StallOut
    );
endinterface

// File: rtl/data_memory_responder.sv
// Multi-cycle data memory with byte/half/word access and sign-extended loads.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    data_memory_responder_if.slave  bus
);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam int unsigned ADDR_LO_W = IDX_W + 2;
    localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } stateT;

    stateT                state;
    stateT                stateNext;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cntNext;
    logic                 accept;
    logic                 doAccess;

    logic                 readyQ;
    logic                 doneQ;
    logic                 misalignQ;
    logic [31:0]          readDataQ;

    logic [ADDR_LO_W-1:0] addrQ;
    logic [31:0]          wdataQ;
    logic                 writeQ;
    logic                 byteQ;
    logic                 halfQ;

    logic [31:0]          mem [DEPTH_WORDS];

    logic [IDX_W-1:0]     wordIdx;
    logic [31:0]          rdWord_c;
    logic                 misalign_c;
    logic [3:0]           byteEn_c;
    logic [31:0]          wrLanes_c;
    logic [31:0]          loadData_c;
    logic [7:0]           byteSel_c;
    logic [15:0]          halfSel_c;
    logic                 unusedAddrHi_c;

    assign bus.ReadyOut    = readyQ;
    assign bus.DoneOut     = doneQ;
    assign bus.ReadDataOut = readDataQ;
    assign bus.MisalignOut = misalignQ;
    assign bus.StallOut    = bus.ReqIn & ~doneQ;

    // Address bits above the array range alias and are deliberately dropped.
    assign unusedAddrHi_c = ^bus.AddressIn[31:ADDR_LO_W];

    // State, counter and registered handshake outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            readyQ    <= 1'b1;
            doneQ     <= 1'b0;
            misalignQ <= 1'b0;
            readDataQ <= '0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            readyQ <= (stateNext == ST_IDLE);
            doneQ  <= (stateNext == ST_RESP);
            if (doAccess) begin
                misalignQ <= misalign_c;
                readDataQ <= loadData_c;
            end else if (state == ST_RESP) begin
                misalignQ <= 1'b0;
            end
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        accept    = 1'b0;
        doAccess  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.ReqIn && (bus.MemReadIn || bus.MemWriteIn)) begin
                    accept    = 1'b1;
                    cntNext   = CNT_W'(LATENCY - 1);
                    stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    doAccess  = 1'b1;
                    stateNext = ST_RESP;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            ST_RESP: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Request capture so inputs may change while the access is pending.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            addrQ  <= '0;
            wdataQ <= '0;
            writeQ <= 1'b0;
            byteQ  <= 1'b0;
            halfQ  <= 1'b0;
        end else if (accept) begin
            addrQ  <= bus.AddressIn[ADDR_LO_W-1:0];
            wdataQ <= bus.WriteDataIn;
            writeQ <= bus.MemWriteIn;
            byteQ  <= bus.LoadStoreByteIn;
            halfQ  <= bus.LoadStoreHalfIn & ~bus.LoadStoreByteIn;
        end
    end

    // Lane selection, alignment check and load extension.
    always_comb begin
        wordIdx    = addrQ[ADDR_LO_W-1:2];
        rdWord_c   = mem[wordIdx];
        byteSel_c  = rdWord_c[{addrQ[1:0], 3'b000} +: 8];
        halfSel_c  = addrQ[1] ? rdWord_c[31:16] : rdWord_c[15:0];
        misalign_c = 1'b0;
        byteEn_c   = 4'b1111;
        wrLanes_c  = wdataQ;
        loadData_c = rdWord_c;
        if (byteQ) begin
            byteEn_c   = 4'b0001 << addrQ[1:0];
            wrLanes_c  = {4{wdataQ[7:0]}};
            loadData_c = {{24{byteSel_c[7]}}, byteSel_c};
        end else if (halfQ) begin
            misalign_c = addrQ[0];
            byteEn_c   = addrQ[1] ? 4'b1100 : 4'b0011;
            wrLanes_c  = {2{wdataQ[15:0]}};
            loadData_c = {{16{halfSel_c[15]}}, halfSel_c};
        end else begin
            misalign_c = (addrQ[1:0] != 2'b00);
        end
        if (writeQ || misalign_c) begin
            loadData_c = '0;
        end
    end

    // Array write; contents are intentionally not reset.
    always_ff @(posedge Clk) begin
        if (doAccess && writeQ && !misalign_c) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn_c[i]) begin
                    mem[wordIdx][8*i +: 8] <= wrLanes_c[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder.
module tb_data_memory_responder;
    logic clk;
    logic rstN;
    int   passCnt;
    int   totalCnt;
    logic [31:0] rdata;
    logic        mis;

    data_memory_responder_if bus();

    data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .Clk   (clk),
        .Rst_n (rstN),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clearReq();
        bus.ReqIn           = 1'b0;
        bus.MemReadIn       = 1'b0;
        bus.MemWriteIn      = 1'b0;
        bus.LoadStoreByteIn = 1'b0;
        bus.LoadStoreHalfIn = 1'b0;
        bus.AddressIn       = '0;
        bus.WriteDataIn     = '0;
    endtask

    task automatic setReq(input logic rd, input logic wr, input logic b, input logic h,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus.ReqIn           = 1'b1;
        bus.MemReadIn       = rd;
        bus.MemWriteIn      = wr;
        bus.LoadStoreByteIn = b;
        bus.LoadStoreHalfIn = h;
        bus.AddressIn       = addr;
        bus.WriteDataIn     = wdata;
    endtask

    // One transaction starting at a negedge with the responder idle.
    task automatic xact(input string tag, input logic rd, input logic wr, input logic b,
                        input logic h, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd_out, output logic mis_out);
        int n;
        check({tag, ".ready"}, 32'(bus.ReadyOut), 32'd1);
        setReq(rd, wr, b, h, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        n = 1;
        clearReq();
        while (!bus.DoneOut && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'd3);
        rd_out  = bus.ReadDataOut;
        mis_out = bus.MisalignOut;
        @(negedge clk);
        check({tag, ".doneFall"}, {30'd0, bus.DoneOut, bus.MisalignOut}, 32'd0);
    endtask

    initial begin
        passCnt  = 0;
        totalCnt = 0;
        clearReq();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(bus.ReadyOut), 32'd1);
        check("rst.done", 32'(bus.DoneOut), 32'd0);
        check("rst.rdata", bus.ReadDataOut, 32'd0);
        check("rst.mis", 32'(bus.MisalignOut), 32'd0);
        check("rst.stall", 32'(bus.StallOut), 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        // Request with neither read nor write is ignored.
        setReq(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        repeat (3) @(negedge clk);
        check("noop.ready", 32'(bus.ReadyOut), 32'd1);
        check("noop.done", 32'(bus.DoneOut), 32'd0);
        clearReq();
        @(negedge clk);

        // Word store then load.
        xact("sw10", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, rdata, mis);
        check("sw10.rdata", rdata, 32'd0);
        xact("lw10", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, rdata, mis);
        check("lw10.rdata", rdata, 32'hDEADBEEF);
        check("lw10.mis", 32'(mis), 32'd0);
        check("lw10.hold", bus.ReadDataOut, 32'hDEADBEEF);

        // Byte store into a cleared word, signed byte load.
        xact("sw0", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, rdata, mis);
        xact("sb11", 1'b0, 1'b1, 1'b1, 1'b0, 32'h11, 32'hAAAA_AA80, rdata, mis);
        xact("lw10b", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, rdata, mis);
        check("lw10b.rdata", rdata, 32'h00008000);
        xact("lb11", 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 32'h0, rdata, mis);
        check("lb11.rdata", rdata, 32'hFFFFFF80);

        // Upper half store, half/word/byte loads.
        xact("sh12", 1'b0, 1'b1, 1'b0, 1'b1, 32'h12, 32'h5555_7FFF, rdata, mis);
        xact("lh12", 1'b1, 1'b0, 1'b0, 1'b1, 32'h12, 32'h0, rdata, mis);
        check("lh12.rdata", rdata, 32'h00007FFF);
        xact("lh10", 1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, rdata, mis);
        check("lh10.rdata", rdata, 32'hFFFF8000);
        xact("lw10c", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, rdata, mis);
        check("lw10c.rdata", rdata, 32'h7FFF8000);
        xact("lb13", 1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0, rdata, mis);
        check("lb13.rdata", rdata, 32'h0000007F);

        // Misaligned accesses.
        xact("lw13", 1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0, rdata, mis);
        check("lw13.rdata", rdata, 32'd0);
        check("lw13.mis", 32'(mis), 32'd1);
        xact("lh11", 1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 32'h0, rdata, mis);
        check("lh11.rdata", rdata, 32'd0);
        check("lh11.mis", 32'(mis), 32'd1);
        xact("sw13", 1'b0, 1'b1, 1'b0, 1'b0, 32'h13, 32'h12345678, rdata, mis);
        check("sw13.mis", 32'(mis), 32'd1);
        xact("sh11", 1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 32'h0000_1234, rdata, mis);
        check("sh11.mis", 32'(mis), 32'd1);
        xact("lw10d", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, rdata, mis);
        check("lw10d.rdata", rdata, 32'h7FFF8000);

        // Read and write both set acts as a store.
        xact("rw30", 1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'hCAFEF00D, rdata, mis);
        check("rw30.rdata", rdata, 32'd0);
        xact("lw30", 1'b1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0, rdata, mis);
        check("lw30.rdata", rdata, 32'hCAFEF00D);

        // Reset during WAIT abandons the pending store.
        xact("sw20", 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h11111111, rdata, mis);
        setReq(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h22222222);
        @(posedge clk);
        @(negedge clk);
        clearReq();
        check("rstmid.busy", 32'(bus.ReadyOut), 32'd0);
        #2 rstN = 1'b0;
        #1;
        check("rstmid.ready", 32'(bus.ReadyOut), 32'd1);
        check("rstmid.done", 32'(bus.DoneOut), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        xact("lw20", 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, rdata, mis);
        check("lw20.rdata", rdata, 32'h11111111);

        // Back-to-back requests held high; 0x1010 aliases word 0x10.
        setReq(1'b1, 1'b0, 1'b0, 1'b0, 32'h1010, 32'h0);
        #1;
        check("b2b.stall0", 32'(bus.StallOut), 32'd1);
        @(negedge clk);
        check("b2b.stall1", 32'(bus.StallOut), 32'd1);
        @(negedge clk);
        check("b2b.stall2", {30'd0, bus.StallOut, bus.DoneOut}, 32'b10);
        @(negedge clk);
        check("b2b.done3", {30'd0, bus.StallOut, bus.DoneOut}, 32'b01);
        check("b2b.rdata1", bus.ReadDataOut, 32'h7FFF8000);
        setReq(1'b1, 1'b0, 1'b1, 1'b0, 32'h1013, 32'h0);
        @(negedge clk);
        check("b2b.idle4", {29'd0, bus.ReadyOut, bus.StallOut, bus.DoneOut}, 32'b110);
        @(negedge clk);
        check("b2b.accept5", {29'd0, bus.ReadyOut, bus.StallOut, bus.DoneOut}, 32'b010);
        @(negedge clk);
        check("b2b.wait6", {30'd0, bus.StallOut, bus.DoneOut}, 32'b10);
        @(negedge clk);
        check("b2b.done7", {30'd0, bus.StallOut, bus.DoneOut}, 32'b01);
        check("b2b.rdata2", bus.ReadDataOut, 32'h0000007F);
        clearReq();
        @(negedge clk);
        check("b2b.end", {29'd0, bus.ReadyOut, bus.StallOut, bus.DoneOut}, 32'b100);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
